data_mem_core: RTL and testbench



---
 rtl/data_mem_core.sv | 137 +++++++++++++
 tb/tb_data_mem_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_core.sv
// data_mem_core
// 256-byte data memory for the RV32 load/store path. The storage is 64 words of
// 32 bits, and each byte lane can be written on its own. Stores are
// synchronous and byte-lane masked. Loads are combinational. A load returns
// the addressed byte, half or word, right-aligned and then sign- or
// zero-extended.
//
// Ports
//   clk       in   1   rising-edge clock for writes
//   rst_n     in   1   asynchronous active-low reset, clears every word
//   CE        in   1   chip enable; low blocks both reads and writes
//   MemRead   in   1   load enable
//   MemWrite  in   1   store enable
//   MemLen    in   3   [1:0] size (00 none, 01 byte, 10 half, 11 word),
//                      [2] unsigned load (zero-extend)
//   addr      in   8   byte address: word index addr[7:2], lane addr[1:0]
//   in        in  32   store data, right-aligned
//   out       out 32   load data, right-aligned and extended
module data_mem_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CE,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  MemLen,
  input  logic [7:0]  addr,
  input  logic [31:0] in,
  output logic [31:0] out
);

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  logic [31:0] mem_q [0:63];

  logic [1:0]  size;
  logic [5:0]  widx;
  logic [1:0]  lane;
  logic [3:0]  byteen;
  logic [31:0] ram_in;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [7:0]  sign_ex;
  logic [31:0] out_d;

  assign size = MemLen[1:0];
  assign widx = addr[7:2];
  assign lane = addr[1:0];

  // Byte-lane enables. A half uses addr[1] only. A word ignores the lane bits.
  always_comb begin
    byteen = 4'b0000;
    unique case (size)
      SZ_BYTE: byteen = 4'b0001 << lane;
      SZ_HALF: byteen = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byteen = 4'b1111;
      default: byteen = 4'b0000;
    endcase
  end

  // Store data is replicated across the word. Each enabled lane then takes
  // the byte that sits at its own position, so no shifter is needed.
  always_comb begin
    ram_in = 32'h0000_0000;
    unique case (size)
      SZ_BYTE: ram_in = {4{in[7:0]}};
      SZ_HALF: ram_in = {2{in[15:0]}};
      SZ_WORD: ram_in = in;
      default: ram_in = 32'h0000_0000;
    endcase
  end

  assign wr_en = CE & MemWrite & (size != SZ_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 64; w++) begin
        mem_q[w] <= 32'h0000_0000;
      end
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (byteen[l]) begin
          mem_q[widx][8*l +: 8] <= ram_in[8*l +: 8];
        end
      end
    end
  end

  // Read path. A store in the same cycle is not bypassed, so the old word is
  // shown until the clock edge.
  assign rd_word = mem_q[widx];

  always_comb begin
    rd_byte = 8'h00;
    unique case (lane)
      2'b00: rd_byte = rd_word[7:0];
      2'b01: rd_byte = rd_word[15:8];
      2'b10: rd_byte = rd_word[23:16];
      2'b11: rd_byte = rd_word[31:24];
      default: rd_byte = 8'h00;
    endcase
  end

  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // Fill byte for the upper bits. It is only used for signed byte and half
  // loads.
  always_comb begin
    sign_ex = 8'h00;
    if (!MemLen[2]) begin
      unique case (size)
        SZ_BYTE: sign_ex = {8{rd_byte[7]}};
        SZ_HALF: sign_ex = {8{rd_half[15]}};
        default: sign_ex = 8'h00;
      endcase
    end
  end

  always_comb begin
    out_d = 32'h0000_0000;
    if (CE && MemRead) begin
      unique case (size)
        SZ_BYTE: out_d = {{3{sign_ex}}, rd_byte};
        SZ_HALF: out_d = {{2{sign_ex}}, rd_half};
        SZ_WORD: out_d = rd_word;
        default: out_d = 32'h0000_0000;
      endcase
    end
  end

  assign out = out_d;

endmodule

// File: tb/tb_data_mem_core.sv
module tb_data_mem_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CE;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemLen;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  int total = 0;
  int bad   = 0;

  // Byte-addressed reference image of the memory.
  logic [7:0] ref_mem [0:255];

  always #5 clk = ~clk;

  data_mem_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .CE       (CE),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .MemLen   (MemLen),
    .addr     (addr),
    .in       (din),
    .out      (dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] len);
    case (len[1:0])
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic c, input logic r,
                                             input logic [2:0] len, input logic [7:0] a);
    int n;
    int base;
    logic [31:0] v;
    n = nbytes(len);
    if (!c || !r || n == 0) return 32'h0;
    base = int'(a) - (int'(a) % n);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
    if (n < 4 && !len[2] && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic model_write(input logic [2:0] len, input logic [7:0] a, input logic [31:0] d);
    int n;
    int base;
    n = nbytes(len);
    if (n == 0) return;
    base = int'(a) - (int'(a) % n);
    for (int k = 0; k < n; k++) ref_mem[base + k] = d[8*k +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  // One bus cycle. The inputs are driven after the falling edge and the load
  // data is checked before the rising edge. The model is updated after the
  // rising edge. When use_exp is set, the fixed value is checked as well.
  task automatic op(input string tag, input logic c, input logic r, input logic w,
                    input logic [2:0] len, input logic [7:0] a, input logic [31:0] d,
                    input logic use_exp, input logic [31:0] exp);
    @(negedge clk);
    CE = c; MemRead = r; MemWrite = w; MemLen = len; addr = a; din = d;
    #1;
    check(tag, dout, model_read(c, r, len, a));
    if (use_exp) check({tag, "_k"}, dout, exp);
    @(posedge clk);
    if (rst_n && c && w) model_write(len, a, d);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0; CE = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    MemLen = 3'b011; addr = 8'h00; din = 32'h0;
    #12;
    check("reset_lw", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op("lw0",       1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'h0000_0000);
    op("sw0",       1, 0, 1, 3'b011, 8'h00, 32'h7FFFFF7F, 1, 32'h0000_0000);
    op("lw_after",  1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'h7FFFFF7F);
    op("sw_zero",   1, 0, 1, 3'b011, 8'h00, 32'h0,        1, 32'h0000_0000);
    op("sb0",       1, 0, 1, 3'b001, 8'h00, 32'h7FFFFF7F, 1, 32'h0000_0000);
    op("lw_sb",     1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'h0000007F);
    op("lb0",       1, 1, 0, 3'b001, 8'h00, 32'h0,        1, 32'h0000007F);
    op("sw1",       1, 0, 1, 3'b011, 8'h00, 32'h7FFFFF7F, 1, 32'h0000_0000);
    op("lh0",       1, 1, 0, 3'b010, 8'h00, 32'h0,        1, 32'hFFFFFF7F);
    op("lhu0",      1, 1, 0, 3'b110, 8'h00, 32'h0,        1, 32'h0000FF7F);
    op("sh2",       1, 0, 1, 3'b010, 8'h02, 32'h7FFFFF7F, 1, 32'h0000_0000);
    op("lw_sh",     1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'hFF7FFF7F);
    op("lh2",       1, 1, 0, 3'b010, 8'h02, 32'h0,        1, 32'hFFFFFF7F);
    op("lbu2",      1, 1, 0, 3'b101, 8'h02, 32'h0,        1, 32'h0000007F);
    op("lb3",       1, 1, 0, 3'b001, 8'h03, 32'h0,        1, 32'hFFFFFFFF);
    op("lwu_ign",   1, 1, 0, 3'b111, 8'h01, 32'h0,        1, 32'hFF7FFF7F);
    op("lnone",     1, 1, 0, 3'b000, 8'h00, 32'h0,        1, 32'h0000_0000);
    op("ce0_rd",    0, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'h0000_0000);
    op("ce0_wr",    0, 0, 1, 3'b011, 8'h00, 32'h12345678, 1, 32'h0000_0000);
    op("lw_ce0",    1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'hFF7FFF7F);
    op("rd0",       1, 0, 0, 3'b011, 8'h00, 32'h0,        1, 32'h0000_0000);
    op("swnone",    1, 0, 1, 3'b000, 8'h00, 32'h12345678, 1, 32'h0000_0000);
    op("lw_none",   1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'hFF7FFF7F);
    op("rw_same",   1, 1, 1, 3'b011, 8'h00, 32'hAABBCCDD, 1, 32'hFF7FFF7F);
    op("lw_rw",     1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'hAABBCCDD);
    op("sw_top",    1, 0, 1, 3'b011, 8'hFF, 32'h80008001, 1, 32'h0000_0000);
    op("lh_top",    1, 1, 0, 3'b010, 8'hFE, 32'h0,        1, 32'hFFFF8000);
    op("lb_top",    1, 1, 0, 3'b001, 8'hFF, 32'h0,        1, 32'hFFFFFF80);

    for (int i = 0; i < 600; i++) begin
      logic c, r, w;
      logic [2:0] len;
      logic [7:0] a;
      c   = ($urandom_range(0, 9) != 0);
      r   = ($urandom_range(0, 4) != 0);
      w   = ($urandom_range(0, 2) == 0);
      len = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      op("rand", c, r, w, len, a, $urandom, 1'b0, 32'h0);
    end

    // Reset asserted in the middle of a cycle clears the contents at once.
    op("pre_rst_w", 1, 0, 1, 3'b011, 8'h10, 32'hDEADBEEF, 1, 32'h0000_0000);
    op("pre_rst_r", 1, 1, 0, 3'b011, 8'h10, 32'h0,        1, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", dout, 32'h0);
    model_clear();
    MemWrite = 1'b1; din = 32'h55555555;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    check("rst_blk_wr", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst_w", 1, 0, 1, 3'b011, 8'h10, 32'h01020304, 1, 32'h0000_0000);
    op("post_rst_r", 1, 1, 0, 3'b011, 8'h10, 32'h0,        1, 32'h01020304);
    op("post_rst_0", 1, 1, 0, 3'b011, 8'h00, 32'h0,        1, 32'h0000_0000);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] len;
      logic [7:0] a;
      len = 3'($urandom_range(0, 7));
      a   = 8'($urandom_range(0, 31));
      op("rand2", 1'b1, 1'b1, ($urandom_range(0, 1) == 1), len, a, $urandom, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
